char_rom_mport: RTL and testbench
=================================

Name: char_rom_mport

Overview:
- Multi-channel read front-end for a shared character/glyph ROM macro.
- Up to c_CH_NUM display or OSD requesters issue glyph-row reads over valid/ready.
- The block arbitrates them onto the single ROM port and tracks each in-flight read through the ROM's fixed latency.
- It returns the data to the originating channel through a per-channel response FIFO with backpressure, so one stalled consumer never blocks the others.

Parameters:
- c_CH_NUM, 4, number of requester channels (1..8)
- c_ADDR_WIDTH, 10, ROM address width
- c_DATA_WIDTH, 32, ROM data width
- c_ROM_LATENCY, 1, cycles from ROM address to valid rom_rd_data (1 = no output reg, 2 = output reg)
- c_RSP_DEPTH, 4, per-channel response FIFO depth (power of 2, >= c_ROM_LATENCY+1)
- c_ARB_MODE, "ROUND_ROBIN", arbitration mode, "ROUND_ROBIN" or "FIXED" (channel 0 highest priority)

Ports:
- clk, input, 1, single clock for all logic and the ROM
- rst, input, 1, asynchronous active-high reset
- req_valid, input, c_CH_NUM, per-channel read request
- req_addr, input, c_CH_NUM*c_ADDR_WIDTH, per-channel address; channel i occupies bits [i*AW +: AW]
- req_ready, output, c_CH_NUM, per-channel request accept
- rsp_valid, output, c_CH_NUM, per-channel response available
- rsp_data, output, c_CH_NUM*c_DATA_WIDTH, per-channel response data (FIFO head)
- rsp_ready, input, c_CH_NUM, per-channel response consume
- rom_addr, output, c_ADDR_WIDTH, address to ROM macro
- rom_clk_en, output, 1, ROM clock enable; high when a grant is issued
- rom_rd_data, input, c_DATA_WIDTH, ROM read data
- busy, output, 1, high if any read is in flight or any FIFO is non-empty

Behaviour:
- Eligibility: channel i is eligible when req_valid[i]=1 and (fifo_count[i] + inflight[i]) < c_RSP_DEPTH. This credit rule guarantees no FIFO overflow.
- Arbitration:
  - At most one grant per cycle; req_ready is combinational, one-hot or zero.
  - A request is accepted when req_valid[i] & req_ready[i].
  - The requester holds req_addr stable until it is accepted.
- ROUND_ROBIN:
  - The priority pointer resets to 0.
  - The search order is ptr, ptr+1, ... mod c_CH_NUM.
  - After a grant to g, ptr <= (g+1) mod c_CH_NUM.
  - With no grant, ptr is held.
- FIXED: the lowest-index eligible channel wins; no pointer.
- Grant cycle:
  - rom_addr = req_addr of the granted channel (combinational mux) and rom_clk_en=1.
  - With no grant, rom_addr holds its last registered-select value and rom_clk_en=0.
- Tag pipeline:
  - A shift register of c_ROM_LATENCY stages carries {valid, channel id}.
  - When the tag exits, rom_rd_data is pushed into that channel's FIFO.
  - Push happens exactly c_ROM_LATENCY cycles after the accept cycle.
  - inflight[i] increments on accept and decrements on push; a simultaneous accept and push leaves it unchanged.
- Response FIFO (per channel):
  - First-word-fall-through; rsp_valid[i] = not empty; rsp_data[i] = head.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop: both take effect and the count is unchanged.
  - Pointers wrap modulo c_RSP_DEPTH.
  - Read-to-response latency on an empty FIFO: c_ROM_LATENCY+1 cycles after accept (FIFO registered).
- Full throughput: a single channel with rsp_ready held high sustains one accept per cycle.
- Reset (asynchronous, any time):
  - req_ready=0, rsp_valid=0, rsp_data=0, rom_clk_en=0, rom_addr=0, busy=0.
  - FIFOs are emptied, inflight counters and the pointer go to 0, and tag valids are cleared.
  - ROM data returning after reset for pre-reset reads is discarded.
- busy = OR of all tag valids and all FIFO non-empty flags, registered (one-cycle lag permitted).

Test Plan:
- Single read, latency 1:
  - Stimulus: ROM returns {addr,22'h0}; ch0 requests addr 10'h05.
  - Required: req_ready[0]=1 in the same cycle; rom_addr=5, rom_clk_en=1; rsp_valid[0] rises 2 cycles later with data 32'h01400000.
- Round-robin fairness:
  - Stimulus: all 4 channels hold req_valid with rsp_ready=1.
  - Required: grant order 0,1,2,3,0,1...; each channel receives every 4th response.
- Backpressure isolation:
  - Stimulus: ch1 rsp_ready=0, other channels free-running.
  - Required: ch1 receives exactly 4 grants, then req_ready[1] stays 0; channels 0, 2 and 3 continue at 1/3 rate each.
  - Then: releasing ch1 drains its 4 words in order and grants resume.
- FIXED mode:
  - Stimulus: ch0 and ch2 request continuously.
  - Required: only ch0 is granted; ch2 is granted only after ch0 deasserts or ch0 runs out of credit.
- Reset mid-flight:
  - Stimulus: c_ROM_LATENCY=2, rst pulsed one cycle after an accept.
  - Required: all outputs are 0 immediately; no rsp_valid appears afterward; the pointer restarts at 0.
- Latency-2 streaming:
  - Stimulus: c_ROM_LATENCY=2; ch3 requests addresses 0..7 back-to-back.
  - Required: 8 responses in order, one per cycle; the first rsp_valid appears 3 cycles after the first accept.

Source files
------------

// File: rtl/char_rom_mport.sv
// Multi-channel read front-end for a shared glyph ROM: arbitrates requesters onto the single
// ROM port, tracks reads through the fixed ROM latency and returns data via per-channel FIFOs.
module char_rom_mport #(
    parameter int    c_CH_NUM      = 4,
    parameter int    c_ADDR_WIDTH  = 10,
    parameter int    c_DATA_WIDTH  = 32,
    parameter int    c_ROM_LATENCY = 1,
    parameter int    c_RSP_DEPTH   = 4,
    parameter string c_ARB_MODE    = "ROUND_ROBIN"
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [c_CH_NUM-1:0]              req_valid,
    input  logic [c_CH_NUM*c_ADDR_WIDTH-1:0] req_addr,
    output logic [c_CH_NUM-1:0]              req_ready,
    output logic [c_CH_NUM-1:0]              rsp_valid,
    output logic [c_CH_NUM*c_DATA_WIDTH-1:0] rsp_data,
    input  logic [c_CH_NUM-1:0]              rsp_ready,
    output logic [c_ADDR_WIDTH-1:0]          rom_addr,
    output logic                             rom_clk_en,
    input  logic [c_DATA_WIDTH-1:0]          rom_rd_data,
    output logic                             busy
);
    // Handshake: a request transfers in a cycle where req_valid[i] & req_ready[i]; a response
    // transfers where rsp_valid[i] & rsp_ready[i]. Requesters hold req_addr until accepted.

    localparam int CW = (c_CH_NUM > 1) ? $clog2(c_CH_NUM) : 1;
    localparam int PW = $clog2(c_RSP_DEPTH);
    localparam int NW = $clog2(c_RSP_DEPTH + 1);
    localparam logic [NW:0] DEPTH_V = (NW + 1)'(c_RSP_DEPTH);
    localparam bit FIXED_PRIO = (c_ARB_MODE == "FIXED");

    logic [CW-1:0]           rr_ptr;
    logic [CW-1:0]           base;
    logic [CW-1:0]           idx_c;
    int                      idx;
    logic [c_CH_NUM-1:0]     elig;
    logic                    gnt_vld;
    logic [CW-1:0]           gnt_id;
    logic [c_ADDR_WIDTH-1:0] addr_q;

    logic [c_ROM_LATENCY-1:0] tag_v;
    logic [CW-1:0]            tag_id [c_ROM_LATENCY];
    logic                     push_vld;
    logic [CW-1:0]            push_id;

    logic [NW-1:0]           infl   [c_CH_NUM];
    logic [NW-1:0]           fcnt   [c_CH_NUM];
    logic [PW-1:0]           wr_ptr [c_CH_NUM];
    logic [PW-1:0]           rd_ptr [c_CH_NUM];
    logic [c_DATA_WIDTH-1:0] mem    [c_CH_NUM][c_RSP_DEPTH];
    logic [c_CH_NUM-1:0]     push, pop, not_empty;
    logic                    busy_q;

    // Credit rule: accepted-but-unconsumed reads never exceed the FIFO depth.
    always_comb begin
        for (int i = 0; i < c_CH_NUM; i++) begin
            elig[i] = req_valid[i] && (({1'b0, fcnt[i]} + {1'b0, infl[i]}) < DEPTH_V);
        end
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        idx_c   = '0;
        base    = FIXED_PRIO ? '0 : rr_ptr;
        if (!rst) begin
            for (int k = 0; k < c_CH_NUM; k++) begin
                idx   = (int'(base) + k) % c_CH_NUM;
                idx_c = CW'(idx);
                if (!gnt_vld && elig[idx_c]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = idx_c;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < c_CH_NUM; i++) begin
            req_ready[i] = gnt_vld && (gnt_id == CW'(i));
        end
        rom_clk_en = gnt_vld;
        rom_addr   = gnt_vld ? req_addr[gnt_id*c_ADDR_WIDTH +: c_ADDR_WIDTH] : addr_q;
    end

    assign push_vld = tag_v[c_ROM_LATENCY-1];
    assign push_id  = tag_id[c_ROM_LATENCY-1];

    always_comb begin
        for (int i = 0; i < c_CH_NUM; i++) begin
            not_empty[i] = (fcnt[i] != '0);
            push[i]      = push_vld && (push_id == CW'(i));
            pop[i]       = not_empty[i] && rsp_ready[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
            addr_q <= '0;
            tag_v  <= '0;
            busy_q <= 1'b0;
            for (int s = 0; s < c_ROM_LATENCY; s++) begin
                tag_id[s] <= '0;
            end
            for (int i = 0; i < c_CH_NUM; i++) begin
                infl[i]   <= '0;
                fcnt[i]   <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            if (gnt_vld) begin
                addr_q <= rom_addr;
                if (!FIXED_PRIO) begin
                    rr_ptr <= (gnt_id == CW'(c_CH_NUM - 1)) ? '0 : gnt_id + 1'b1;
                end
            end
            // Tag stage 0 lines up with the ROM address register; the last stage
            // coincides with valid rom_rd_data.
            tag_v[0]  <= gnt_vld;
            tag_id[0] <= gnt_id;
            for (int s = 1; s < c_ROM_LATENCY; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
            for (int i = 0; i < c_CH_NUM; i++) begin
                if (req_ready[i] && !push[i]) begin
                    infl[i] <= infl[i] + 1'b1;
                end else if (!req_ready[i] && push[i]) begin
                    infl[i] <= infl[i] - 1'b1;
                end
                if (push[i] && !pop[i]) begin
                    fcnt[i] <= fcnt[i] + 1'b1;
                end else if (!push[i] && pop[i]) begin
                    fcnt[i] <= fcnt[i] - 1'b1;
                end
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + 1'b1;
                end
            end
            busy_q <= (|tag_v) || (|not_empty);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < c_CH_NUM; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= rom_rd_data;
            end
        end
    end

    // Empty FIFOs present zero so stale storage never leaks out after reset.
    always_comb begin
        for (int i = 0; i < c_CH_NUM; i++) begin
            rsp_valid[i] = not_empty[i];
            rsp_data[i*c_DATA_WIDTH +: c_DATA_WIDTH] = not_empty[i] ? mem[i][rd_ptr[i]] : '0;
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_char_rom_mport.sv
// Bench for char_rom_mport: three instances (round-robin/lat1, fixed/lat1, round-robin/lat2)
// share one stimulus stream; a credit/latency reference model feeds per-channel expected queues.
module tb_char_rom_mport;
    localparam int NI  = 3;
    localparam int NC  = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int DEPTH = 4;
    localparam int CKW = NC * DW;

    function automatic int lat_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    function automatic bit fixed_of(input int i);
        return (i == 1);
    endfunction

    function automatic logic [DW-1:0] rom_fn(input logic [AW-1:0] a);
        return {a, 22'h0};
    endfunction

    logic clk = 1'b0;
    logic rst;
    logic [NC-1:0]    req_valid   [NI];
    logic [NC*AW-1:0] req_addr    [NI];
    logic [NC-1:0]    req_ready   [NI];
    logic [NC-1:0]    rsp_valid   [NI];
    logic [NC*DW-1:0] rsp_data    [NI];
    logic [NC-1:0]    rsp_ready   [NI];
    logic [AW-1:0]    rom_addr    [NI];
    logic             rom_clk_en  [NI];
    logic [DW-1:0]    rom_rd_data [NI];
    logic             busy        [NI];

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    char_rom_mport #(.c_ROM_LATENCY(1), .c_ARB_MODE("ROUND_ROBIN")) u_rr (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_addr(req_addr[0]),
        .req_ready(req_ready[0]), .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .rsp_ready(rsp_ready[0]), .rom_addr(rom_addr[0]), .rom_clk_en(rom_clk_en[0]),
        .rom_rd_data(rom_rd_data[0]), .busy(busy[0]));

    char_rom_mport #(.c_ROM_LATENCY(1), .c_ARB_MODE("FIXED")) u_fx (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_addr(req_addr[1]),
        .req_ready(req_ready[1]), .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .rsp_ready(rsp_ready[1]), .rom_addr(rom_addr[1]), .rom_clk_en(rom_clk_en[1]),
        .rom_rd_data(rom_rd_data[1]), .busy(busy[1]));

    char_rom_mport #(.c_ROM_LATENCY(2), .c_ARB_MODE("ROUND_ROBIN")) u_l2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_addr(req_addr[2]),
        .req_ready(req_ready[2]), .rsp_valid(rsp_valid[2]), .rsp_data(rsp_data[2]),
        .rsp_ready(rsp_ready[2]), .rom_addr(rom_addr[2]), .rom_clk_en(rom_clk_en[2]),
        .rom_rd_data(rom_rd_data[2]), .busy(busy[2]));

    // ROM macros: address register gated by clk_en, optional free-running output register
    for (genvar g = 0; g < NI; g++) begin : g_rom
        logic [AW-1:0] a_q;
        logic [DW-1:0] d_q;
        always @(posedge clk) begin
            if (rom_clk_en[g]) a_q <= rom_addr[g];
            d_q <= rom_fn(a_q);
        end
        assign rom_rd_data[g] = (lat_of(g) == 2) ? d_q : rom_fn(a_q);
    end

    // scoreboard state
    logic [DW-1:0] exp_q [NI*NC][$];
    int            rdy_q [NI*NC][$];
    int            ptr       [NI];
    logic [AW-1:0] last_addr [NI];
    int            prev_occ  [NI];
    logic [NC-1:0] acc_last  [NI];
    int            seq_n     [NI];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int inst, input logic [CKW-1:0] act,
                         input logic [CKW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    // Reference arbiter: each cycle, the first channel in priority order that is requesting
    // and has fewer than DEPTH reads outstanding (accepted, not yet consumed) must be granted.
    always @(negedge clk) begin
        int g;
        int occ;
        int ch;
        logic [NC-1:0] exp_rdy;
        logic [AW-1:0] exp_addr;
        for (int i = 0; i < NI; i++) begin
            g = -1;
            if (rst) begin
                for (int c = 0; c < NC; c++) begin
                    exp_q[i*NC+c].delete();
                    rdy_q[i*NC+c].delete();
                end
                ptr[i]       = 0;
                last_addr[i] = '0;
                check("rsp_data_in_reset", i, CKW'(rsp_data[i]), '0);
            end else begin
                for (int k = 0; k < NC; k++) begin
                    ch = (ptr[i] + k) % NC;
                    if (g < 0 && req_valid[i][ch] && exp_q[i*NC+ch].size() < DEPTH) g = ch;
                end
            end
            occ = 0;
            for (int c = 0; c < NC; c++) occ += exp_q[i*NC+c].size();
            exp_rdy  = (g >= 0) ? (NC'(1) << g) : '0;
            exp_addr = (g >= 0) ? req_addr[i][g*AW +: AW] : last_addr[i];
            check("req_ready", i, CKW'(req_ready[i]), CKW'(exp_rdy));
            check("rom_clk_en", i, CKW'(rom_clk_en[i]), CKW'(g >= 0));
            check("rom_addr", i, CKW'(rom_addr[i]), CKW'(exp_addr));
            check("busy", i, CKW'(busy[i]), CKW'(prev_occ[i] > 0));
            acc_last[i] = req_valid[i] & req_ready[i];
            if (g >= 0) begin
                exp_q[i*NC+g].push_back(rom_fn(exp_addr));
                rdy_q[i*NC+g].push_back(cyc + lat_of(i) + 1);
                last_addr[i] = exp_addr;
                if (!fixed_of(i)) ptr[i] = (g + 1) % NC;
            end
            prev_occ[i] = occ;
        end
    end

    // Monitor: a read becomes visible lat+1 cycles after its accept and leaves in order.
    always @(negedge clk) begin
        int  k;
        logic ev;
        #1;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NC; c++) begin
                k  = i * NC + c;
                ev = !rst && (exp_q[k].size() > 0) && (rdy_q[k][0] <= cyc);
                check("rsp_valid", i, CKW'(rsp_valid[i][c]), CKW'(ev));
                if (rsp_valid[i][c] && ev && rsp_ready[i][c]) begin
                    check("rsp_data", i, CKW'(rsp_data[i][c*DW +: DW]), CKW'(exp_q[k][0]));
                    void'(exp_q[k].pop_front());
                    void'(rdy_q[k].pop_front());
                end
            end
        end
    end

    // driver: a channel only changes its request after it was accepted (or while idle)
    task automatic step(input logic [NC-1:0] want, input logic [NC-1:0] rdy,
                        input bit rnd, input bit seq);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NC; c++) begin
                if (!req_valid[i][c] || acc_last[i][c]) begin
                    if (seq) begin
                        if (req_valid[i][c] && acc_last[i][c]) seq_n[i]++;
                        req_valid[i][c] = want[c] && (seq_n[i] < 8);
                        req_addr[i][c*AW +: AW] = AW'(seq_n[i]);
                    end else begin
                        req_valid[i][c] = want[c] && (!rnd || $urandom_range(0, 2) != 0);
                        req_addr[i][c*AW +: AW] = AW'($urandom_range(0, 1023));
                    end
                end
            end
            rsp_ready[i] = rnd ? NC'($urandom_range(0, 15)) : rdy;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = '0;
            req_addr[i]  = '0;
            rsp_ready[i] = '0;
            seq_n[i]     = 0;
            acc_last[i]  = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) req_valid[i] = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single read on ch0, address 5
        for (int i = 0; i < NI; i++) begin
            req_valid[i] = 4'b0001;
            req_addr[i]  = '0;
            req_addr[i][AW-1:0] = 10'h005;
            rsp_ready[i] = 4'hF;
        end
        repeat (6) step(4'h0, 4'hF, 1'b0, 1'b0);

        // all channels, free-running consumers
        repeat (40) step(4'hF, 4'hF, 1'b0, 1'b0);
        // ch1 consumer stalled, then released
        repeat (40) step(4'hF, 4'b1101, 1'b0, 1'b0);
        repeat (20) step(4'hF, 4'hF, 1'b0, 1'b0);
        // ch0 + ch2 only, then ch0 out of credit, then ch0 idle
        repeat (20) step(4'b0101, 4'hF, 1'b0, 1'b0);
        repeat (20) step(4'b0101, 4'b1110, 1'b0, 1'b0);
        repeat (10) step(4'b0100, 4'hF, 1'b0, 1'b0);
        repeat (12) step(4'h0, 4'hF, 1'b0, 1'b0);

        // reset one cycle after an accept on ch1 (pointer at 2 before reset)
        step(4'b0010, 4'hF, 1'b0, 1'b0);
        step(4'h0, 4'hF, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) step(4'hF, 4'hF, 1'b0, 1'b0);
        repeat (10) step(4'h0, 4'hF, 1'b0, 1'b0);

        // ch3 streams addresses 0..7 back-to-back
        for (int i = 0; i < NI; i++) seq_n[i] = 0;
        repeat (16) step(4'b1000, 4'hF, 1'b0, 1'b1);

        // random traffic and backpressure
        repeat (300) step(4'hF, 4'hF, 1'b1, 1'b0);
        repeat (30) step(4'h0, 4'hF, 1'b0, 1'b0);

        @(negedge clk);
        #2;
        for (int i = 0; i < NI; i++) begin
            for (int c = 0; c < NC; c++) begin
                check("final_drained", i, CKW'(exp_q[i*NC+c].size()), '0);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
